// File: rtl/mult4s_product_accumulator.sv
// -----------------------------------------------------------------------------
// mult4s_product_accumulator
//
// Accumulates a stream of signed products from the registered 4x4 multiplier
// into a dot-product sum. The upstream sequencer marks the final product of a
// vector with in_last. The finished sum, beat count and overflow flag are then
// held on a valid/ready output port, and input is stalled until the result is
// taken.
//
// Build option:
//   MULT4S_ACC_SAT_EN - when defined, an overflowing addition clamps the
//                       accumulator to the most positive / most negative
//                       ACC_W value instead of wrapping. out_ovf behaves the
//                       same in both builds, and so does the port list.
// -----------------------------------------------------------------------------
module mult4s_product_accumulator #(
    parameter int PROD_W = 8,   // signed product width
    parameter int ACC_W  = 16,  // signed accumulator / result width, >= PROD_W
    parameter int CNT_W  = 8    // beat counter width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    // ACC: taking beats into the running sum. OUT: a finished result is held.
    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             beat_accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum_raw;
    logic [ACC_W-1:0] sum_next;
    logic             beat_ovf;
    logic [CNT_W-1:0] cnt_next;

    // ------------------------------------------------------------------
    // Per-beat arithmetic
    // ------------------------------------------------------------------
    assign beat_accept = in_valid && in_ready;

    // The product is two's complement, so it is sign-extended: -64 (0xC0)
    // becomes 0xFFC0 at ACC_W=16.
    assign prod_ext = ACC_W'($signed(in_product));
    assign sum_raw  = acc_q + prod_ext;

    // Signed overflow: both addends share a sign and the sum's sign differs.
    assign beat_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MULT4S_ACC_SAT_EN
    // On overflow the sign of the (shared) addend sign tells the direction:
    // negative operands overflow to the minimum, positive to the maximum.
    assign sum_next = !beat_ovf      ? sum_raw :
                      acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                       {1'b0, {(ACC_W-1){1'b1}}};
`else
    // Plain two's-complement wrap-around; overflow is only flagged.
    assign sum_next = sum_raw;
`endif

    // Beat counter saturates at all-ones rather than wrapping to zero.
    assign cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave ACC on the last beat, return once the result is taken.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: if (beat_accept && in_last) state_d = ST_OUT;
            ST_OUT: if (out_ready)              state_d = ST_ACC;
            default:                            state_d = ST_ACC;
        endcase
    end

    // Outputs decoded from state only; in_ready never looks at out_ready.
    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_OUT);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Next values for the accumulator and result registers.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (beat_accept) begin
            if (in_last) begin
                // Publish the completed vector and start the next one clean.
                out_sum_d   = sum_next;
                out_count_d = cnt_next;
                out_ovf_d   = ovf_q | beat_ovf;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d       = sum_next;
                cnt_d       = cnt_next;
                ovf_d       = ovf_q | beat_ovf;
            end
        end
    end

    // Accumulator and result registers. Result registers keep their value
    // after the handshake; only out_valid (from state) drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult4s_product_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for mult4s_product_accumulator.
// Two instances share clock and reset: one at ACC_W=16 and one at ACC_W=8 for
// the overflow cases. A behavioural integer model predicts every result and
// pushes it to a per-instance queue; monitors pop and compare whenever a
// result is handed off. Inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult4s_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance 0: ACC_W=16
    logic        in_valid16 = 1'b0, in_ready16, in_last16 = 1'b0;
    logic [7:0]  in_product16 = '0;
    logic        out_valid16, out_ready16 = 1'b1, out_ovf16;
    logic [15:0] out_sum16;
    logic [7:0]  out_count16;

    // Instance 1: ACC_W=8
    logic        in_valid8 = 1'b0, in_ready8, in_last8 = 1'b0;
    logic [7:0]  in_product8 = '0;
    logic        out_valid8, out_ready8 = 1'b1, out_ovf8;
    logic [7:0]  out_sum8;
    logic [7:0]  out_count8;

    mult4s_product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_product(in_product16), .in_last(in_last16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_sum(out_sum16), .out_count(out_count16), .out_ovf(out_ovf16)
    );

    mult4s_product_accumulator #(.PROD_W(8), .ACC_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_product(in_product8), .in_last(in_last8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .out_count(out_count8), .out_ovf(out_ovf8)
    );

    typedef struct {
        int sum;
        int count;
        bit ovf;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = ACC_W 16, index 1 = ACC_W 8.
    int m_acc[2];
    int m_cnt[2];
    bit m_ovf[2];

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
    endfunction

    // Integer-range model of one accepted beat.
    function automatic void model_beat(input int id, input int p, input bit last);
        int   w;
        int   maxv;
        int   minv;
        int   s;
        bit   o;
        exp_t e;
        w    = (id == 0) ? 16 : 8;
        maxv = (1 << (w - 1)) - 1;
        minv = -(1 << (w - 1));
        s    = m_acc[id] + p;
        o    = 1'b0;
        if (s > maxv) begin
            o = 1'b1;
`ifdef MULT4S_ACC_SAT_EN
            s = maxv;
`else
            s = s - (1 << w);
`endif
        end else if (s < minv) begin
            o = 1'b1;
`ifdef MULT4S_ACC_SAT_EN
            s = minv;
`else
            s = s + (1 << w);
`endif
        end
        m_acc[id] = s;
        m_ovf[id] = m_ovf[id] | o;
        m_cnt[id] = (m_cnt[id] == 255) ? 255 : m_cnt[id] + 1;
        if (last) begin
            e.sum   = m_acc[id];
            e.count = m_cnt[id];
            e.ovf   = m_ovf[id];
            if (id == 0) q16.push_back(e);
            else         q8.push_back(e);
            m_acc[id] = 0;
            m_cnt[id] = 0;
            m_ovf[id] = 1'b0;
        end
    endfunction

    // Scoreboard consumer for instance 0.
    always @(negedge clk) begin
        if (!rst && out_valid16 && out_ready16) begin
            exp_t e;
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL sb16_unexpected: got sum=%0d count=%0d ovf=%0b, required no result",
                         $signed(out_sum16), out_count16, out_ovf16);
            end else begin
                e = q16.pop_front();
                if (int'($signed(out_sum16)) != e.sum || int'(out_count16) != e.count ||
                    out_ovf16 !== e.ovf) begin
                    errors++;
                    $display("FAIL sb16_result: got sum=%0d count=%0d ovf=%0b, required sum=%0d count=%0d ovf=%0b",
                             $signed(out_sum16), out_count16, out_ovf16, e.sum, e.count, e.ovf);
                end
            end
        end
    end

    // Scoreboard consumer for instance 1.
    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            exp_t e;
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL sb8_unexpected: got sum=%0d count=%0d ovf=%0b, required no result",
                         $signed(out_sum8), out_count8, out_ovf8);
            end else begin
                e = q8.pop_front();
                if (int'($signed(out_sum8)) != e.sum || int'(out_count8) != e.count ||
                    out_ovf8 !== e.ovf) begin
                    errors++;
                    $display("FAIL sb8_result: got sum=%0d count=%0d ovf=%0b, required sum=%0d count=%0d ovf=%0b",
                             $signed(out_sum8), out_count8, out_ovf8, e.sum, e.count, e.ovf);
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input int id, input int p, input bit last);
        bit done;
        done = 1'b0;
        if (id == 0) begin
            in_valid16 = 1'b1; in_product16 = p[7:0]; in_last16 = last;
        end else begin
            in_valid8 = 1'b1; in_product8 = p[7:0]; in_last8 = last;
        end
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if ((id == 0) ? in_ready16 : in_ready8) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (id == 0) in_valid16 = 1'b0;
        else         in_valid8  = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL beat_accept_timeout: dut %0d got no in_ready, required acceptance within 50 cycles", id);
        end else begin
            model_beat(id, p, last);
        end
    endtask

    task automatic idle(input int n);
        in_valid16 = 1'b0;
        in_valid8  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input int n);
        rst        = 1'b1;
        in_valid16 = 1'b0;
        in_valid8  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_clear();
        q16.delete();
        q8.delete();
    endtask

    task automatic test_reset();
        apply_reset(2);
        @(negedge clk);
        checks++;
        if (out_valid16 !== 1'b0 || out_sum16 !== 16'h0000 || out_count16 !== 8'h00 ||
            out_ovf16 !== 1'b0 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b sum=%h count=%0d ovf=%0b ready=%0b, required 0 0000 0 0 1",
                     out_valid16, out_sum16, out_count16, out_ovf16, in_ready16);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready16 = 1'b1;
        send_beat(0, 12, 1'b0);
        send_beat(0, -6, 1'b0);
        send_beat(0, 64, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid16 !== 1'b1 || in_ready16 !== 1'b0 || out_sum16 !== 16'd70 ||
            out_count16 !== 8'd3) begin
            errors++;
            $display("FAIL b2b_latency: got valid=%0b ready=%0b sum=%0d count=%0d, required 1 0 70 3",
                     out_valid16, in_ready16, out_sum16, out_count16);
        end
        @(negedge clk);
        checks++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: got valid=%0b ready=%0b, required 0 1", out_valid16, in_ready16);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sign_and_bubbles();
        send_beat(0, -64, 1'b1);
        @(negedge clk);
        checks++;
        if (out_sum16 !== 16'hFFC0 || out_count16 !== 8'd1) begin
            errors++;
            $display("FAIL sign_extend: got sum=%h count=%0d, required ffc0 1", out_sum16, out_count16);
        end
        @(posedge clk);
        #1;
        send_beat(0, 5, 1'b0);
        idle(3);
        send_beat(0, 7, 1'b1);
        idle(2);
    endtask

    task automatic test_backpressure();
        out_ready16 = 1'b0;
        send_beat(0, 3, 1'b1);
        in_valid16   = 1'b1;
        in_product16 = 8'd9;
        in_last16    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid16 !== 1'b1 || in_ready16 !== 1'b0 || out_sum16 !== 16'd3 ||
                out_count16 !== 8'd1 || out_ovf16 !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got valid=%0b ready=%0b sum=%0d count=%0d ovf=%0b, required 1 0 3 1 0",
                         out_valid16, in_ready16, out_sum16, out_count16, out_ovf16);
            end
            @(posedge clk);
            #1;
        end
        out_ready16 = 1'b1;
        send_beat(0, 9, 1'b1);
        idle(2);
    endtask

    task automatic test_overflow();
        send_beat(1, 64, 1'b0);
        send_beat(1, 64, 1'b1);
        @(negedge clk);
        checks++;
`ifdef MULT4S_ACC_SAT_EN
        if (out_sum8 !== 8'h7F || out_ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: got sum=%h ovf=%0b, required 7f 1", out_sum8, out_ovf8);
        end
`else
        if (out_sum8 !== 8'h80 || out_ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: got sum=%h ovf=%0b, required 80 1", out_sum8, out_ovf8);
        end
`endif
        @(posedge clk);
        #1;
        send_beat(1, -8, 1'b1);
        send_beat(1, 100, 1'b0);
        send_beat(1, 100, 1'b0);
        send_beat(1, -50, 1'b1);
        send_beat(1, -100, 1'b0);
        send_beat(1, -100, 1'b1);
        idle(3);
    endtask

    task automatic test_reset_midvector_and_saturation();
        send_beat(0, 10, 1'b0);
        send_beat(0, 20, 1'b0);
        apply_reset(1);
        send_beat(0, 5, 1'b1);
        idle(2);
        for (int k = 0; k < 300; k++) send_beat(0, 0, 1'b0);
        send_beat(0, 0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_count16 !== 8'd255) begin
            errors++;
            $display("FAIL count_saturate: got count=%0d, required 255", out_count16);
        end
        @(posedge clk);
        #1;
        idle(2);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_back_to_back();
        test_sign_and_bubbles();
        test_backpressure();
        test_overflow();
        test_reset_midvector_and_saturation();
        idle(3);
        checks++;
        if (q16.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL results_drained: got %0d/%0d results outstanding, required 0/0",
                     q16.size(), q8.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
